// File: rtl/microseq_stack.sv
// Next-MPC logic for a MIC-1 style control path, extended with a micro-subroutine
// return stack, a pipeline stall and sticky stack-error flags.
module microseq_stack #(
  parameter int ADDR_W      = 9,
  parameter int MBR_W       = 8,
  parameter int STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               N,
  input  logic                               Z,
  input  logic [MBR_W-1:0]                   MBR,
  input  logic [ADDR_W-1:0]                  next_addr,
  input  logic                               jmpc,
  input  logic                               jamn,
  input  logic                               jamz,
  input  logic                               call,
  input  logic                               ret,
  input  logic                               stall,
  output logic [ADDR_W-1:0]                  MPC,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               err_ovf,
  output logic                               err_unf
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SLOTS   = 1 << IDX_W;

  logic [ADDR_W-1:0] stack_mem [SLOTS];
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] ret_addr;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  push_idx;
  logic              empty;
  logic              full;

  // Branch target is pure OR-merging of the jam conditions into the MIR field.
  always_comb begin
    target = next_addr;
    target[ADDR_W-1] = next_addr[ADDR_W-1] | (jamn & N) | (jamz & Z);
    if (jmpc) target = target | ADDR_W'(MBR);
  end

  assign ret_addr = MPC + ADDR_W'(1);
  assign empty    = (depth == '0);
  assign full     = (depth == DEPTH_W'(STACK_DEPTH));
  assign top_idx  = IDX_W'(depth - DEPTH_W'(1));
  assign push_idx = IDX_W'(depth);

  // One-cycle registered update; ret outranks call, stall freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MPC     <= RESET_ADDR;
      depth   <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
      for (int i = 0; i < SLOTS; i++) stack_mem[i] <= '0;
    end else if (!stall) begin
      if (ret) begin
        if (!empty) begin
          MPC <= stack_mem[top_idx];
          if (call) stack_mem[top_idx] <= ret_addr;
          else      depth <= depth - DEPTH_W'(1);
        end else begin
          MPC     <= RESET_ADDR;
          err_unf <= 1'b1;
        end
      end else if (call) begin
        MPC <= target;
        if (!full) begin
          stack_mem[push_idx] <= ret_addr;
          depth <= depth + DEPTH_W'(1);
        end else begin
          err_ovf <= 1'b1;
        end
      end else begin
        MPC <= target;
      end
    end
  end

endmodule

// File: tb/tb_microseq_stack.sv
// Randomised and directed bench for microseq_stack with a queue-based reference model.
module tb_microseq_stack;

  localparam int ADDR_W = 9;
  localparam int MBR_W  = 8;
  localparam int SD     = 4;
  localparam int W      = ADDR_W + 3 + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              N = 0, Z = 0, jmpc = 0, jamn = 0, jamz = 0;
  logic              call = 0, ret = 0, stall = 0;
  logic [MBR_W-1:0]  MBR = '0;
  logic [ADDR_W-1:0] next_addr = '0;
  logic [ADDR_W-1:0] MPC;
  logic [2:0]        depth;
  logic              err_ovf, err_unf;

  microseq_stack #(.ADDR_W(ADDR_W), .MBR_W(MBR_W), .STACK_DEPTH(SD), .RESET_ADDR('0)) dut (
    .clk(clk), .rst(rst), .N(N), .Z(Z), .MBR(MBR), .next_addr(next_addr),
    .jmpc(jmpc), .jamn(jamn), .jamz(jamz), .call(call), .ret(ret), .stall(stall),
    .MPC(MPC), .depth(depth), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // reference model: the stack is a plain queue, top at the back
  int       mpc_m = 0;
  int       stk_m[$];
  bit       ovf_m = 0, unf_m = 0;
  logic [W-1:0] exp_q[$];
  int       n_checks = 0, n_pass = 0;

  function automatic logic [W-1:0] pack_model();
    return {mpc_m[ADDR_W-1:0], 3'(stk_m.size()), ovf_m, unf_m};
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got mpc=%h depth=%0d ovf=%b unf=%b, expected mpc=%h depth=%0d ovf=%b unf=%b",
                  name, got[W-1:5], got[4:2], got[1], got[0], exp[W-1:5], exp[4:2], exp[1], exp[0]);
  endtask

  // driver: apply one cycle of inputs at negedge, advance model, queue expectation
  task automatic drive(input int na, input bit jc, input bit jn, input bit jz, input bit n,
                       input bit z, input int mbr, input bit cl, input bit rt, input bit st);
    int t, r;
    @(negedge clk);
    next_addr = ADDR_W'(na); jmpc = jc; jamn = jn; jamz = jz; N = n; Z = z;
    MBR = MBR_W'(mbr); call = cl; ret = rt; stall = st;
    t = (na & 'h1FF) | ((((jn & n) | (jz & z)) ? 1 : 0) << (ADDR_W - 1)) | (jc ? (mbr & 'hFF) : 0);
    r = (mpc_m + 1) % (1 << ADDR_W);
    if (!st) begin
      if (rt) begin
        if (stk_m.size() > 0) begin
          mpc_m = stk_m[$];
          if (cl) stk_m[$] = r;
          else void'(stk_m.pop_back());
        end else begin
          mpc_m = 0;
          unf_m = 1;
        end
      end else if (cl) begin
        if (stk_m.size() < SD) stk_m.push_back(r);
        else ovf_m = 1;
        mpc_m = t;
      end else begin
        mpc_m = t;
      end
    end
    exp_q.push_back(pack_model());
  endtask

  task automatic go(input int na);                drive(na, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_call(input int na);           drive(na, 0, 0, 0, 0, 0, 0, 1, 0, 0); endtask
  task automatic do_ret();                        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); endtask

  // reset asserted between edges; outputs must clear before the next posedge
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("async_reset", {MPC, depth, err_ovf, err_unf}, '0);
    mpc_m = 0; stk_m.delete(); ovf_m = 0; unf_m = 0;
    @(negedge clk);
    call = 0; ret = 0; stall = 1;
    rst = 1'b1;
  endtask

  // monitor: every posedge with a pending expectation, compare shortly after the edge
  always @(posedge clk) begin
    #1;
    if (rst && exp_q.size() > 0) check("mpc_step", {MPC, depth, err_ovf, err_unf}, exp_q.pop_front());
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_values", {MPC, depth, err_ovf, err_unf}, '0);
    rst = 1'b1;
    stall = 1;

    // legacy branching
    drive('h005, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    drive('h005, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    drive('h100, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    // JMPC dispatch
    drive('h000, 1, 0, 0, 0, 0, 'h59, 0, 0, 0);
    drive('h100, 1, 0, 0, 0, 0, 'hA7, 0, 0, 0);
    drive('h1FF, 1, 1, 1, 1, 1, 'hFF, 0, 0, 0);
    // nested call / return
    go('h010);
    do_call('h080);
    do_call('h0C0);
    do_ret();
    do_ret();
    // overflow then underflow, flags stay sticky
    for (int i = 0; i < 5; i++) do_call('h020 + i * 'h11);
    for (int i = 0; i < 5; i++) do_ret();
    go('h033);
    // stall with call pending
    for (int i = 0; i < 3; i++) drive('h0AA, 0, 0, 0, 0, 0, 0, 1, 0, 1);

    // coroutine swap and return-address wrap
    do_reset();
    go('h030);
    do_call('h0FF);
    drive('h055, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    do_ret();
    drive('h000, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    go('h1FF);
    do_call('h040);
    do_ret();

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 15);
      drive($urandom_range(0, 511), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 255), op < 5 || op == 12, (op >= 5 && op < 9) || op == 12, op >= 13);
      if (i == 200) do_reset();
    end

    // depth 3 with overflow flag set, then asynchronous reset mid-cycle
    do_reset();
    for (int i = 0; i < 5; i++) do_call('h100 + i);
    do_ret();
    do_reset();

    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
